// File: rtl/iob_mem_arbiter.sv
// Round-robin arbiter sharing one IOb native slave port between N_MASTERS
// IOb native masters. One transaction in flight at a time: the winning
// request is registered and forwarded, and the slave response is routed back
// combinationally. A watchdog completes stalled transactions with ERR_DATA.

// Per-master response lane: drives {rdata,ready} only for the owner of the
// transaction, and only in its completion cycle. Otherwise the lane is zero.
module iob_mem_arbiter_lane #(
    parameter int DATA_W = 32
) (
    input  logic              sel,
    input  logic              done,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W:0]   resp
);

    assign resp = (sel && done) ? {rdata, 1'b1} : '0;

endmodule

module iob_mem_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF,
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int RESP_W = DATA_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp,
    output logic [N_MASTERS-1:0]          grant_o,
    output logic                          timeout_o
);

    localparam int PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    // Last watchdog count; only meaningful when the watchdog is enabled.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                              state, state_nxt;
    logic [PTR_W-1:0]                    ptr;
    logic [PTR_W-1:0]                    grant_idx;
    logic [CNT_W-1:0]                    cnt;

    logic [N_MASTERS-1:0]                m_valid;
    logic [N_MASTERS-1:0][REQ_W-2:0]     m_body;   // {addr,wdata,wstrb}

    logic                                win_found;
    logic [PTR_W-1:0]                    win_idx;
    logic [PTR_W-1:0]                    cand;

    logic                                s_ready;
    logic [DATA_W-1:0]                   s_rdata;
    logic                                resp_hit, to_hit, done;
    logic [DATA_W-1:0]                   done_rdata;

    assign s_ready = s_resp[0];
    assign s_rdata = s_resp[RESP_W-1:1];

    // Split the flat master bus into valid bits and request bodies.
    for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
        assign m_valid[i] = m_req[i*REQ_W + REQ_W-1];
        assign m_body[i]  = m_req[i*REQ_W +: REQ_W-1];
    end

    // First requester at or after ptr, searching upward with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            cand = PTR_W'((int'(ptr) + k) % N_MASTERS);
            if (!win_found && m_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Slave ready beats the watchdog when both land in the same cycle.
    assign resp_hit   = (state == BUSY) && s_ready;
    assign to_hit     = (state == BUSY) && !s_ready && (TIMEOUT != 0) && (cnt == CNT_LAST);
    assign done       = resp_hit || to_hit;
    assign done_rdata = s_ready ? s_rdata : ERR_DATA;

    // Route the completion back to the granted master only.
    for (genvar i = 0; i < N_MASTERS; i++) begin : g_lane
        iob_mem_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
            .sel   (grant_o[i]),
            .done  (done),
            .rdata (done_rdata),
            .resp  (m_resp[i*RESP_W +: RESP_W])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: grant when anyone asks, release on completion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = BUSY;
            BUSY:    if (done)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, grant, fairness pointer and watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_req     <= '0;
            grant_o   <= '0;
            grant_idx <= '0;
            ptr       <= '0;
            cnt       <= '0;
            timeout_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        s_req     <= {1'b1, m_body[win_idx]};
                        grant_o   <= N_MASTERS'(1) << win_idx;
                        grant_idx <= win_idx;
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        s_req[REQ_W-1] <= 1'b0;
                        grant_o        <= '0;
                        ptr            <= (grant_idx == PTR_W'(N_MASTERS-1)) ? '0 : grant_idx + 1'b1;
                        if (to_hit) timeout_o <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_mem_arbiter.sv
// Directed bench for iob_mem_arbiter (N=2, TIMEOUT=8). Expected responses
// are queued when a request is issued and popped when a ready pulse appears.
module tb_iob_mem_arbiter;

    localparam int N      = 2;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int TO     = 8;
    localparam int REQ_W  = 1 + AW + DW + DW/8;
    localparam int RESP_W = DW + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [N*REQ_W-1:0]   m_req;
    logic [N*RESP_W-1:0]  m_resp;
    logic [REQ_W-1:0]     s_req;
    logic [RESP_W-1:0]    s_resp;
    logic [N-1:0]         grant_o;
    logic                 timeout_o;

    logic                 mv [N];
    logic [AW-1:0]        ma [N];
    logic [DW-1:0]        mw [N];
    logic [DW/8-1:0]      ms [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_mreq
        assign m_req[g*REQ_W +: REQ_W] = {mv[g], ma[g], mw[g], ms[g]};
    end

    iob_mem_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TO),
        .ERR_DATA  (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_req     (m_req),
        .m_resp    (m_resp),
        .s_req     (s_req),
        .s_resp    (s_resp),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    // Slave model: read data is a fixed function of the address so the
    // origin of every response is recognisable (0x100 -> 0x1234).
    function automatic logic [DW-1:0] slv_rd(input logic [AW-1:0] a);
        return a ^ 32'h0000_1334;
    endfunction

    int   slv_lat;
    bit   slv_mute;
    logic slv_rdy;
    logic idle_pulse;
    int   sl_cnt;

    assign s_resp = {slv_rd(s_req[REQ_W-2 -: AW]), slv_rdy | idle_pulse};

    // Ready arrives slv_lat cycles after s_req.valid rises, for one cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            slv_rdy <= 1'b0;
            sl_cnt  <= 0;
        end else if (slv_rdy) begin
            slv_rdy <= 1'b0;
            sl_cnt  <= 0;
        end else if (s_req[REQ_W-1] && !slv_mute) begin
            if (sl_cnt == slv_lat - 1) slv_rdy <= 1'b1;
            else                       sl_cnt  <= sl_cnt + 1;
        end else begin
            sl_cnt <= 0;
        end
    end

    typedef struct {
        int            m;
        logic [DW-1:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [REQ_W-1:0] obs, input logic [REQ_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int m, input logic [DW-1:0] d);
        exp_t e;
        e.m = m;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] w,
                           input logic [DW/8-1:0] s);
        mv[i] = 1'b1;
        ma[i] = a;
        mw[i] = w;
        ms[i] = s;
    endtask

    // Step negedges until a ready pulse appears; compare it against the
    // scoreboard head, drop that master's valid, and require all other
    // lanes to be zero on every sampled cycle.
    task automatic wait_resp(input int budget, output int n);
        bit               hit;
        logic [RESP_W-1:0] r;
        exp_t             e;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < N; i++) begin
                r = m_resp[i*RESP_W +: RESP_W];
                if (r[0] && !hit) begin
                    hit = 1'b1;
                    chk("sb_nonempty", REQ_W'(sb.size() != 0), REQ_W'(1));
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("resp_master", REQ_W'(i), REQ_W'(e.m));
                        chk("resp_rdata", REQ_W'(r[RESP_W-1:1]), REQ_W'(e.d));
                    end
                    mv[i] = 1'b0;
                end else begin
                    chk("quiet_lane", REQ_W'(r), '0);
                end
            end
        end
        n_cmp++;
        assert (hit) else begin
            n_err++;
            $error("FAIL resp_wait: got no ready want ready within %0d cycles", budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < N; i++) set_req(i, '0, '0, '0);
        for (int i = 0; i < N; i++) mv[i] = 1'b0;
        slv_lat    = 1;
        slv_mute   = 1'b0;
        idle_pulse = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_grant", REQ_W'(grant_o), '0);
        chk("rst_sreq", s_req, '0);
        chk("rst_timeout", REQ_W'(timeout_o), '0);
        chk("rst_mresp", REQ_W'(m_resp), '0);
        rst = 1'b1;
        @(negedge clk);

        // Contention from ptr=0: m0 then m1, twice
        for (int rep = 0; rep < 2; rep++) begin
            set_req(0, 32'h200, '0, '0);
            set_req(1, 32'h300, '0, '0);
            push(0, slv_rd(32'h200));
            push(1, slv_rd(32'h300));
            @(negedge clk);
            chk("cont_grant0", REQ_W'(grant_o), REQ_W'(2'b01));
            wait_resp(20, n);
            @(negedge clk);
            chk("cont_bubble", REQ_W'(grant_o), '0);
            @(negedge clk);
            chk("cont_grant1", REQ_W'(grant_o), REQ_W'(2'b10));
            wait_resp(20, n);
            @(negedge clk);
        end

        // Single read, slave latency 3
        slv_lat = 3;
        set_req(0, 32'h100, '0, '0);
        push(0, 32'h1234);
        @(negedge clk);
        chk("rd_svalid", REQ_W'(s_req[REQ_W-1]), REQ_W'(1));
        chk("rd_saddr", REQ_W'(s_req[REQ_W-2 -: AW]), REQ_W'(32'h100));
        chk("rd_grant", REQ_W'(grant_o), REQ_W'(2'b01));
        wait_resp(20, n);
        chk("rd_latency", REQ_W'(n), REQ_W'(3));
        chk("rd_grant_done", REQ_W'(grant_o), REQ_W'(2'b01));
        @(negedge clk);
        chk("rd_grant_clr", REQ_W'(grant_o), '0);
        chk("rd_svalid_clr", REQ_W'(s_req[REQ_W-1]), '0);

        // Write from m1 with m0 also waiting; ptr=1 so m1 wins
        slv_lat = 2;
        set_req(0, 32'h80, '0, '0);
        set_req(1, 32'h40, 32'hCAFEF00D, 4'hF);
        push(1, slv_rd(32'h40));
        push(0, slv_rd(32'h80));
        @(negedge clk);
        chk("wr_sreq", s_req, {1'b1, 32'h40, 32'hCAFEF00D, 4'hF});
        chk("wr_grant", REQ_W'(grant_o), REQ_W'(2'b10));
        // Disturb the master inputs: the forwarded request must not follow
        ma[1] = 32'hFFFF_FFF0;
        mw[1] = '0;
        @(negedge clk);
        chk("wr_sreq_hold", s_req, {1'b1, 32'h40, 32'hCAFEF00D, 4'hF});
        wait_resp(20, n);
        wait_resp(20, n);
        @(negedge clk);

        // Slave ready coincides with the last watchdog count
        slv_lat = TO - 1;
        set_req(0, 32'h600, '0, '0);
        push(0, slv_rd(32'h600));
        @(negedge clk);
        wait_resp(20, n);
        chk("coin_latency", REQ_W'(n), REQ_W'(TO - 1));
        @(negedge clk);
        chk("coin_timeout", REQ_W'(timeout_o), '0);

        // Slave ready while IDLE is ignored
        idle_pulse = 1'b1;
        @(negedge clk);
        chk("idlep_mresp", REQ_W'(m_resp), '0);
        chk("idlep_grant", REQ_W'(grant_o), '0);
        chk("idlep_svalid", REQ_W'(s_req[REQ_W-1]), '0);
        idle_pulse = 1'b0;
        @(negedge clk);
        chk("idlep_grant2", REQ_W'(grant_o), '0);
        chk("idlep_timeout", REQ_W'(timeout_o), '0);

        // Silent slave: ready with ERR_DATA in the 8th BUSY cycle (count 7)
        slv_mute = 1'b1;
        set_req(0, 32'h500, '0, '0);
        push(0, 32'hDEADBEEF);
        @(negedge clk);
        wait_resp(20, n);
        chk("to_latency", REQ_W'(n), REQ_W'(TO - 1));
        chk("to_flag_pre", REQ_W'(timeout_o), '0);
        @(negedge clk);
        chk("to_flag", REQ_W'(timeout_o), REQ_W'(1));
        slv_mute = 1'b0;
        slv_lat  = 1;
        set_req(1, 32'h700, '0, '0);
        push(1, slv_rd(32'h700));
        @(negedge clk);
        wait_resp(20, n);
        @(negedge clk);
        chk("to_sticky", REQ_W'(timeout_o), REQ_W'(1));

        // Move ptr to 1, then reset in the middle of an m1 transaction
        set_req(0, 32'h800, '0, '0);
        push(0, slv_rd(32'h800));
        @(negedge clk);
        wait_resp(20, n);
        @(negedge clk);
        slv_mute = 1'b1;
        set_req(1, 32'h900, '0, '0);
        @(negedge clk);
        chk("rstb_grant", REQ_W'(grant_o), REQ_W'(2'b10));
        #2 rst = 1'b0;
        #1;
        chk("arst_grant", REQ_W'(grant_o), '0);
        chk("arst_sreq", s_req, '0);
        chk("arst_timeout", REQ_W'(timeout_o), '0);
        chk("arst_mresp", REQ_W'(m_resp), '0);
        @(negedge clk);
        chk("arst_mresp2", REQ_W'(m_resp), '0);
        rst      = 1'b1;
        slv_mute = 1'b0;
        slv_lat  = 1;
        set_req(0, 32'hA00, '0, '0);
        set_req(1, 32'hB00, '0, '0);
        push(0, slv_rd(32'hA00));
        push(1, slv_rd(32'hB00));
        wait_resp(20, n);
        wait_resp(20, n);
        chk("sb_drained", REQ_W'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
